// File: rtl/regfile_pkg.sv
// Shared constants, clear-FSM state type and lane helper for the
// scoreboarded integer register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Base bit of lane k in a packed bus of w-bit lanes.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_clear_fsm.sv
// Soft-clear sequencer: walks indices 1..NREG-1, issuing one clear write
// per cycle, and reports IDLE so the array can gate normal traffic.
module rf_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          clr_busy,
  output logic          idle
);

  clr_state_e    state;
  logic [AW-1:0] clr_idx;

  // Sequencer state, index and registered busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      clr_idx  <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_idx  <= AW'(1);
            clr_busy <= 1'b1;
          end else begin
            state    <= IDLE;
            clr_idx  <= clr_idx;
            clr_busy <= 1'b0;
          end
        end
        CLEAR: begin
          // Terminal compare at NREG-1 means the increment never wraps into use.
          if (clr_idx == AW'(NREG - 1)) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end else begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
          end
          clr_idx <= clr_idx + AW'(1);
        end
        default: begin
          state    <= IDLE;
          clr_idx  <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = clr_idx;
  assign idle     = (state == IDLE);

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with hardwired x0, write-to-read bypass,
// per-register busy scoreboard and a sequenced soft clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int AW     = $clog2(NREG),
  parameter int NUM_RD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   ra,
  output logic [NUM_RD*XLEN-1:0] rd,
  output logic [NUM_RD-1:0]      rd_rdy,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [XLEN-1:0]        wd,
  input  logic                   iss_vld,
  input  logic [AW-1:0]          iss_rd,
  output logic                   iss_rdy,
  input  logic                   clr_req,
  output logic                   clr_busy
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            idle;
  logic            wr_ok;

  rf_clear_fsm #(
    .NREG (NREG),
    .AW   (AW)
  ) u_clear (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_busy (clr_busy),
    .idle     (idle)
  );

  assign iss_rdy = idle;
  assign wr_ok   = we && idle && (wa != '0);

  // Register array: clear engine has priority; normal writes only when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_we) begin
      regs[clr_addr] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end else begin
      regs[0] <= '0;
    end
  end

  // Busy scoreboard: a new issue beats a same-cycle writeback to the same register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (clr_we && (clr_addr == AW'(i))) begin
          busy[i] <= 1'b0;
        end else if (iss_vld && idle && (iss_rd == AW'(i))) begin
          busy[i] <= 1'b1;
        end else if (wr_ok && (wa == AW'(i))) begin
          busy[i] <= 1'b0;
        end else begin
          busy[i] <= busy[i];
        end
      end
    end
  end

  // Combinational read ports with x0, reset gating and writeback bypass.
  always_comb begin
    logic [AW-1:0] ra_k;
    ra_k   = '0;
    rd     = '0;
    rd_rdy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra_k = ra[lane_lo(k, AW) +: AW];
      if (!rst) begin
        rd[lane_lo(k, XLEN) +: XLEN] = '0;
        rd_rdy[k]                    = 1'b1;
      end else if (ra_k == '0) begin
        rd[lane_lo(k, XLEN) +: XLEN] = '0;
        rd_rdy[k]                    = 1'b1;
      end else if (wr_ok && (wa == ra_k)) begin
        rd[lane_lo(k, XLEN) +: XLEN] = wd;
        rd_rdy[k]                    = 1'b1;
      end else begin
        rd[lane_lo(k, XLEN) +: XLEN] = regs[ra_k];
        rd_rdy[k]                    = ~busy[ra_k];
      end
    end
  end

endmodule
